uart_fifo_bridge: RTL

Buffering and handshake stage between the CPU bus side and the uart block (9600 baud, x16 oversampled, sysclk domain).
- TX path: 16-entry FIFO. A drain FSM issues one-cycle tx_enable pulses to the uart and tracks uart tx_status (1 = idle).
- RX path: detects each uart rx_status strobe and pushes uart rx_data into a 16-entry FIFO for the CPU.
- The uart's status outputs change on its baud-rate clock, so both status inputs are resynchronised here.

---
 rtl/uart_bridge_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_fifo_bridge.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared defaults and TX drain FSM encoding for uart_fifo_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int BUSY_TIMEOUT_DEF = 2047;

    // TX drain FSM, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with occupancy count. A write
//               to a full FIFO is accepted only when a read pops in the
//               same cycle; a read of an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2+1)'(c_DEPTH);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_rd_ok   = i_rd_en & ~w_empty;
    // a pop frees the slot in the same cycle, so full+pop still accepts the write
    assign w_wr_ok   = i_wr_en & (~w_full | w_rd_ok);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_bridge
// Description : CPU <-> uart buffering stage. TX FIFO drained by a handshake
//               FSM (enable pulse, busy wait with re-issue timeout, done wait);
//               RX FIFO filled on each resynchronised uart rx strobe.
//               Optional build macro UART_RX_OVERRUN_EN enables the sticky
//               rx_overrun flag and the saturating rx_drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     cpu_tx_data,
    input  logic                  cpu_tx_write,
    output logic                  cpu_tx_full,
    output logic [DATA_W-1:0]     cpu_rx_data,
    input  logic                  cpu_rx_read,
    output logic                  cpu_rx_empty,
    output logic [DEPTH_LOG2:0]   tx_fifo_count,
    output logic [DEPTH_LOG2:0]   rx_fifo_count,
    output logic [DATA_W-1:0]     uart_tx_data,
    output logic                  uart_tx_enable,
    input  logic                  uart_tx_status,
    input  logic [DATA_W-1:0]     uart_rx_data,
    input  logic                  uart_rx_status,
    output logic                  rx_overrun,
    output logic [7:0]            rx_drop_count
);

    localparam int                  c_TIMER_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(BUSY_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    // ------------------------------------------------------------------
    // Status resynchronisers (uart drives them from its baud clock)
    // ------------------------------------------------------------------
    logic r_tx_st_meta;
    logic r_tx_st_s;
    logic r_rx_st_meta;
    logic r_rx_st_s;
    logic r_rx_st_prev;
    logic w_rx_push;

    // two-flop synchronisers plus rx edge-detect history; tx idles high
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_tx_st_meta <= 1'b1;
            r_tx_st_s    <= 1'b1;
            r_rx_st_meta <= 1'b0;
            r_rx_st_s    <= 1'b0;
            r_rx_st_prev <= 1'b0;
        end else begin
            r_tx_st_meta <= uart_tx_status;
            r_tx_st_s    <= r_tx_st_meta;
            r_rx_st_meta <= uart_rx_status;
            r_rx_st_s    <= r_rx_st_meta;
            r_rx_st_prev <= r_rx_st_s;
        end
    end

    // rising edge only: one push per strobe however long the strobe lasts
    assign w_rx_push = r_rx_st_s & ~r_rx_st_prev;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_pop;
    logic              w_tx_empty;

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (sysclk),
        .rst       (reset),
        .i_wr_en   (cpu_tx_write),
        .i_wr_data (cpu_tx_data),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_count   (tx_fifo_count)
    );

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (sysclk),
        .rst       (reset),
        .i_wr_en   (w_rx_push),
        .i_wr_data (uart_rx_data),
        .i_rd_en   (cpu_rx_read),
        .o_rd_data (cpu_rx_data),
        .o_count   (rx_fifo_count)
    );

    assign cpu_tx_full  = (tx_fifo_count == c_FULL);
    assign w_tx_empty   = (tx_fifo_count == '0);
    assign cpu_rx_empty = (rx_fifo_count == '0);

    // ------------------------------------------------------------------
    // TX drain FSM
    // ------------------------------------------------------------------
    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [DATA_W-1:0]      r_tx_data;
    logic [DATA_W-1:0]      w_tx_data_nxt;
    logic                   w_tx_enable;

    // state, busy timer and the byte held on the uart data lines
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_tx_data <= w_tx_data_nxt;
        end
    end

    // next state: pop in IDLE, pulse in ISSUE, re-issue the same byte if busy never seen
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_tx_data_nxt = r_tx_data;
        w_tx_pop      = 1'b0;
        w_tx_enable   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_data_nxt = w_tx_head;
                    w_tx_pop      = 1'b1;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                w_tx_enable = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!r_tx_st_s) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_timer_nxt = r_timer + c_TIMER_W'(1);
                end
            end
            WAIT_DONE: begin
                if (r_tx_st_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign uart_tx_enable = w_tx_enable;
    assign uart_tx_data   = r_tx_data;

    // ------------------------------------------------------------------
    // RX overrun reporting
    // ------------------------------------------------------------------
`ifdef UART_RX_OVERRUN_EN
    logic       w_rx_drop;
    logic       r_rx_overrun;
    logic [7:0] r_rx_drop_count;

    // a same-cycle CPU read makes room, so only an unmatched push into full drops
    assign w_rx_drop = w_rx_push & (rx_fifo_count == c_FULL) & ~cpu_rx_read;

    // sticky overrun flag and saturating drop counter
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_rx_overrun    <= 1'b0;
            r_rx_drop_count <= '0;
        end else if (w_rx_drop) begin
            r_rx_overrun <= 1'b1;
            if (r_rx_drop_count != 8'hFF) begin
                r_rx_drop_count <= r_rx_drop_count + 8'd1;
            end
        end
    end

    assign rx_overrun    = r_rx_overrun;
    assign rx_drop_count = r_rx_drop_count;
`else
    assign rx_overrun    = 1'b0;
    assign rx_drop_count = '0;
`endif

endmodule
`default_nettype wire
